fifo_cmd_sequencer: RTL and testbench

Parametrised command-stream sequencer that replays a programmable table of command words into a FIFO-backed output interface (e.g. beep_interface_module) using its write_req / fifo_write_data / full_sig handshake. It supersedes hard-coded per-demo write state machines: the table, its length, inter-write pacing and one-shot/loop mode are runtime-configurable. It sits between a control/demo top level and the FIFO write port.

---
 rtl/fifo_cmd_sequencer_if.sv | 11 +
 rtl/fifo_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_fifo_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cmd_sequencer_if.sv
// FIFO write-port bundle between the command sequencer (master) and the FIFO (slave).
interface fifo_cmd_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              write_req;
    logic [DATA_W-1:0] fifo_write_data;
    logic              full_sig;

    modport master (output write_req, output fifo_write_data, input full_sig);
    modport slave  (input write_req, input fifo_write_data, output full_sig);
endinterface

// File: rtl/fifo_cmd_sequencer.sv
// Replays a programmable command table into a FIFO write port, with per-write
// pacing, one-shot or looping passes, stop abort and full_sig backpressure.
module fifo_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int AW     = 4,
    parameter int GAP_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]      cfg_data,
    input  logic [AW:0]            cfg_len,
    input  logic [GAP_W-1:0]       cfg_gap,
    input  logic                   loop_en,
    input  logic                   start,
    input  logic                   stop,
    fifo_cmd_sequencer_if.master   fifo,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pass_cnt
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t            state, state_nxt;
    logic              done_nxt;
    logic [DATA_W-1:0] table_mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [AW:0]       len_q;
    logic [GAP_W-1:0]  gap_q;
    logic              loop_q;
    logic              launch;
    logic              accept;
    logic              last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign launch = (state == IDLE) && start && !stop;
    assign accept = (state == SEND) && !fifo.full_sig;
    assign last   = ({1'b0, idx} == (len_q - (AW+1)'(1)));

    assign fifo.write_req       = accept;
    assign fifo.fifo_write_data = (state == SEND) ? table_mem[idx] : '0;
    assign busy                 = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    if (cfg_len == '0) done_nxt  = 1'b1;
                    else               state_nxt = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last && !loop_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = (gap_q != '0) ? GAP : SEND;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including the completion pulse.
        if (stop) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            gap_cnt  <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            loop_q   <= 1'b0;
            pass_cnt <= '0;
        end else if (launch) begin
            len_q    <= cfg_len;
            gap_q    <= cfg_gap;
            loop_q   <= loop_en;
            idx      <= '0;
            pass_cnt <= '0;
        end else if (!stop) begin
            if (accept) begin
                gap_cnt <= gap_q;
                if (last) begin
                    idx      <= '0;
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    idx <= idx + AW'(1);
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // The table is only writable while idle so a running pass never sees it change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) table_mem[i] <= '0;
        end else if (cfg_we && (state == IDLE)) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_fifo_cmd_sequencer.sv
// Scoreboard bench: directed runs push expected FIFO words; a negedge monitor checks each write.
module tb_fifo_cmd_sequencer;
    localparam int DATA_W = 8;
    localparam int AW     = 4;
    localparam int GAP_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [AW:0]       cfg_len;
    logic [GAP_W-1:0]  cfg_gap;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic [15:0]       pass_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                acc_q [$];

    fifo_cmd_sequencer_if #(.DATA_W(DATA_W)) bus ();

    fifo_cmd_sequencer #(.DATA_W(DATA_W), .AW(AW), .GAP_W(GAP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_len  (cfg_len),
        .cfg_gap  (cfg_gap),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .fifo     (bus.master),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with write_req high is a FIFO accept at the next edge.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.write_req) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h expected none", bus.fifo_write_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wdata", bus.fifo_write_data, e);
                end
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tab(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_spacing(input string name, input int n, input int sp);
        check({name, "_count"}, acc_q.size(), n);
        for (int i = 1; i < acc_q.size(); i++)
            check({name, "_spacing"}, acc_q[i] - acc_q[i-1], sp);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_len = '0; cfg_gap = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        bus.full_sig = 1'b0;
        step(); step();
        check("rst_write_req", bus.write_req, 0);
        check("rst_wdata", bus.fifo_write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        rst_n = 1'b1;
        step();

        // One-shot, back-to-back
        write_tab(0, 8'h1B); write_tab(1, 8'h44); write_tab(2, 8'h1B);
        cfg_len = 3; cfg_gap = 0; loop_en = 0;
        acc_q.delete();
        exp_q.push_back(8'h1B); exp_q.push_back(8'h44); exp_q.push_back(8'h1B);
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_first_req", bus.write_req, 1);
        step(); step(); step();
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_pass_cnt", pass_cnt, 1);
        check("t1_wdata_idle", bus.fifo_write_data, 0);
        step();
        check("t1_done_once", done, 0);
        wait_drain("t1");
        check_spacing("t1", 3, 1);

        // Gap of 2 idle cycles between words
        cfg_gap = 2;
        acc_q.delete();
        exp_q.push_back(8'h1B); exp_q.push_back(8'h44); exp_q.push_back(8'h1B);
        pulse_start();
        wait_drain("t2");
        check_spacing("t2", 3, 3);
        check("t2_pass_cnt", pass_cnt, 1);

        // Backpressure on the second word
        cfg_gap = 0;
        acc_q.delete();
        exp_q.push_back(8'h1B); exp_q.push_back(8'h44); exp_q.push_back(8'h1B);
        pulse_start();
        step();
        bus.full_sig = 1'b1;
        #1;
        check("t3_stall_comb", bus.write_req, 0);
        check("t3_busy_stalled", busy, 1);
        for (int i = 0; i < 5; i++) step();
        bus.full_sig = 1'b0;
        #1;
        check("t3_resume_data", bus.fifo_write_data, 8'h44);
        wait_drain("t3");
        check("t3_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("t3_stall_gap", acc_q[1] - acc_q[0], 6);
            check("t3_after_gap", acc_q[2] - acc_q[1], 1);
        end
        check("t3_pass_cnt", pass_cnt, 1);

        // Looping pass, stopped after 7 accepts
        write_tab(0, 8'hAA); write_tab(1, 8'h55);
        cfg_len = 2; cfg_gap = 0; loop_en = 1;
        acc_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? 8'hAA : 8'h55);
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_busy_after_stop", busy, 0);
        check("t4_pass_cnt", pass_cnt, 3);
        check("t4_no_done", done, 0);
        check("t4_req_low", bus.write_req, 0);
        step();
        check("t4_no_done_late", done, 0);
        wait_drain("t4");
        check_spacing("t4", 7, 1);

        // Zero-length start: done without writes
        loop_en = 0; cfg_len = 0;
        acc_q.delete();
        pulse_start();
        check("t5_len0_busy", busy, 0);
        check("t5_len0_done", done, 1);
        check("t5_len0_pass", pass_cnt, 0);
        step();
        check("t5_len0_done_once", done, 0);
        check("t5_len0_writes", acc_q.size(), 0);

        // Table write while busy is ignored
        write_tab(0, 8'h11); write_tab(1, 8'h22);
        cfg_len = 2; cfg_gap = 3;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        pulse_start();
        step();
        write_tab(0, 8'hFF);
        wait_drain("t5a");
        cfg_gap = 0;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        pulse_start();
        wait_drain("t5b");

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_start_stop_busy", busy, 0);
        check("t5_start_stop_done", done, 0);

        // Asynchronous reset mid-SEND
        write_tab(0, 8'h5A); write_tab(1, 8'h5B); write_tab(2, 8'h5C);
        cfg_len = 3; cfg_gap = 0; loop_en = 1;
        exp_q.push_back(8'h5A);
        pulse_start();
        step();
        check("t6_req_before_rst", bus.write_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", bus.write_req, 0);
        check("t6_rst_wdata", bus.fifo_write_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_pass", pass_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_leftover", exp_q.size(), 0);
        loop_en = 0;
        acc_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        pulse_start();
        wait_drain("t6");
        check_spacing("t6", 3, 1);
        check("t6_pass_cnt", pass_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
